// File: rtl/mod_inv_seq_if.sv
// Modular-multiplier request bus between the inverse sequencer and the multiplier.
// The master issues operand pairs and the slave returns results a fixed latency later.
interface mod_inv_seq_if #(
    parameter int P_WIDTH = 64
);
    logic               mul_vld_out;
    logic [P_WIDTH-1:0] mul_a_out;
    logic [P_WIDTH-1:0] mul_b_out;
    logic [P_WIDTH-1:0] mul_res_in;

    modport master (
        output mul_vld_out,
        output mul_a_out,
        output mul_b_out,
        input  mul_res_in
    );

    modport slave (
        input  mul_vld_out,
        input  mul_a_out,
        input  mul_b_out,
        output mul_res_in
    );
endinterface

// File: rtl/mod_inv_seq.sv
// Modular inverse sequencer: A^(N-2) mod N by left-to-right square-and-multiply,
// driving an external fixed-latency pipelined modular multiplier.
module mod_inv_seq #(
    parameter int P_WIDTH = 64,
    parameter int MUL_LAT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_in,
    input  logic [P_WIDTH-1:0] a_in,
    input  logic [P_WIDTH-1:0] n_in,
    output logic               busy_out,
    output logic               done_out,
    output logic [P_WIDTH-1:0] inv_out,
    output logic               err_out,
    mod_inv_seq_if.master      mul
);

    localparam int IW = $clog2(P_WIDTH);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_SQ,
        WAIT_SQ,
        ISSUE_MUL,
        WAIT_MUL,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic [P_WIDTH-1:0] a_q, a_d;
    logic [P_WIDTH-1:0] e_q, e_d;
    logic [P_WIDTH-1:0] r_q, r_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [P_WIDTH-1:0] inv_q, inv_d;
    logic               erro_q, erro_d;
    logic               vld_q, vld_d;
    logic [P_WIDTH-1:0] ma_q, ma_d;
    logic [P_WIDTH-1:0] mb_q, mb_d;
    logic               last;

    assign last = (cnt_q == CW'(MUL_LAT - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        e_d     = e_q;
        r_d     = r_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        inv_d   = inv_q;
        erro_d  = erro_q;
        vld_d   = 1'b0;
        ma_d    = ma_q;
        mb_d    = mb_q;

        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    a_d    = a_in;
                    e_d    = n_in - P_WIDTH'(2);
                    r_d    = P_WIDTH'(1);
                    idx_d  = IW'(P_WIDTH - 1);
                    busy_d = 1'b1;
                    err_d  = (a_in == '0) || (n_in < P_WIDTH'(3));
                    state_d = err_d ? FIN : ISSUE_SQ;
                end
            end
            ISSUE_SQ: begin
                cnt_d   = '0;
                state_d = WAIT_SQ;
            end
            WAIT_SQ: begin
                if (last) begin
                    r_d = mul.mul_res_in;
                    if (e_q[idx_q]) begin
                        state_d = ISSUE_MUL;
                    end else if (idx_q == '0) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = ISSUE_SQ;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ISSUE_MUL: begin
                cnt_d   = '0;
                state_d = WAIT_MUL;
            end
            WAIT_MUL: begin
                if (last) begin
                    r_d = mul.mul_res_in;
                    if (idx_q == '0) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = ISSUE_SQ;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered: decode the state being entered.
        if (state_d == FIN) begin
            done_d = 1'b1;
            inv_d  = err_d ? '0 : r_d;
            erro_d = err_d;
        end
        if (state_d == ISSUE_SQ) begin
            vld_d = 1'b1;
            ma_d  = r_d;
            mb_d  = r_d;
        end else if (state_d == ISSUE_MUL) begin
            vld_d = 1'b1;
            ma_d  = r_d;
            mb_d  = a_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            e_q     <= '0;
            r_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            inv_q   <= '0;
            erro_q  <= 1'b0;
            vld_q   <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            e_q     <= e_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            inv_q   <= inv_d;
            erro_q  <= erro_d;
            vld_q   <= vld_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
        end
    end

    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign inv_out         = inv_q;
    assign err_out         = erro_q;
    assign mul.mul_vld_out = vld_q;
    assign mul.mul_a_out   = ma_q;
    assign mul.mul_b_out   = mb_q;

endmodule

// File: tb/tb_mod_inv_seq.sv
// Bench for mod_inv_seq: behavioural pipelined mod-mult plus a right-to-left
// modular exponentiation reference model, randomized operands and primes.
module tb_mod_inv_seq;

    localparam int L = 4;
    localparam logic [63:0] G = 64'hFFFFFFFF00000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic [63:0] a_in = '0;
    logic [63:0] n_in = '0;
    logic        busy_out, done_out, err_out;
    logic [63:0] inv_out;

    mod_inv_seq_if #(.P_WIDTH(64)) mif ();

    mod_inv_seq #(.P_WIDTH(64), .MUL_LAT(L)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_in (start_in),
        .a_in     (a_in),
        .n_in     (n_in),
        .busy_out (busy_out),
        .done_out (done_out),
        .inv_out  (inv_out),
        .err_out  (err_out),
        .mul      (mif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int vld_cnt = 0;
    int done_cnt = 0;
    int consec = 0;
    logic prev_vld = 1'b0;
    logic [63:0] cur_n = 64'd7;

    function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] n);
        logic [127:0] p;
        if (n == 0) return '0;
        p = {64'd0, a} * {64'd0, b};
        return 64'(p % {64'd0, n});
    endfunction

    function automatic logic [63:0] modpow(input logic [63:0] a, input logic [63:0] e,
                                           input logic [63:0] n);
        logic [63:0] r, b;
        r = 64'd1 % n;
        b = a % n;
        while (e != 0) begin
            if (e[0]) r = mulmod(r, b, n);
            b = mulmod(b, b, n);
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic int exp_cycle(input logic [63:0] n);
        return (64 + $countones(n - 64'd2)) * (L + 1) + 1;
    endfunction

    // Multiplier model: result only visible exactly L edges after issue.
    logic [63:0] pipe_d [L];
    bit   [L-1:0] pipe_v = '0;
    logic [63:0] junk = 64'hDEAD_BEEF_0BAD_F00D;

    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
        pipe_v[0] <= mif.mul_vld_out;
        pipe_d[0] <= mulmod(mif.mul_a_out, mif.mul_b_out, cur_n);
        junk <= {$urandom, $urandom};
    end

    assign mif.mul_res_in = pipe_v[L-1] ? pipe_d[L-1] : junk;

    always @(negedge clk) begin
        if (mif.mul_vld_out === 1'b1) begin
            vld_cnt++;
            if (prev_vld) consec++;
        end
        if (done_out === 1'b1) done_cnt++;
        prev_vld = (mif.mul_vld_out === 1'b1);
    end

    task automatic launch(input logic [63:0] a, input logic [63:0] n);
        @(negedge clk);
        start_in = 1'b1;
        a_in = a;
        n_in = n;
        cur_n = n;
        @(posedge clk);
        vld_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic collect(input int limit, input bit hold, output int cyc,
                           output bit timeout, output bit busy1);
        cyc = 1;
        timeout = 1'b0;
        busy1 = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc == 1) begin
                busy1 = busy_out;
                if (!hold) start_in = 1'b0;
                a_in = {$urandom, $urandom};
                n_in = {$urandom, $urandom};
            end
            if (done_out === 1'b1) break;
            if (cyc >= limit) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_chk += 4;
        if (busy_out !== 1'b0 || done_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl busy=%b done=%b required 0 0", busy_out, done_out);
        end
        if (inv_out !== 64'd0 || err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_res inv=%h err=%b required 0 0", inv_out, err_out);
        end
        if (mif.mul_vld_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vld got %b required 0", mif.mul_vld_out);
        end
        if (mif.mul_a_out !== 64'd0 || mif.mul_b_out !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_ops a=%h b=%h required 0", mif.mul_a_out, mif.mul_b_out);
        end
    endtask

    task automatic test_known;
        logic [63:0] ta [4] = '{64'd2, 64'd1, G - 64'd1, 64'd3};
        logic [63:0] tn [4] = '{G, G, G, 64'd7};
        logic [63:0] te [4] = '{64'h7FFFFFFF80000001, 64'd1, 64'hFFFFFFFF00000000, 64'd5};
        int          tc [4] = '{636, exp_cycle(G), exp_cycle(G), 331};
        int          tp [4] = '{127, 127, 127, 66};
        int cyc;
        bit to, b1;
        for (int k = 0; k < 4; k++) begin
            launch(ta[k], tn[k]);
            collect(tc[k] + 20, 1'b0, cyc, to, b1);
            n_chk += 4;
            if (to || cyc != tc[k]) begin
                n_fail++;
                $display("FAIL known_cycle[%0d] got %0d required %0d", k, cyc, tc[k]);
            end
            if (inv_out !== te[k] || err_out !== 1'b0) begin
                n_fail++;
                $display("FAIL known_inv[%0d] got %h/%b required %h/0", k, inv_out, err_out, te[k]);
            end
            if (vld_cnt != tp[k]) begin
                n_fail++;
                $display("FAIL known_pulses[%0d] got %0d required %0d", k, vld_cnt, tp[k]);
            end
            if (b1 !== 1'b1) begin
                n_fail++;
                $display("FAIL known_busy[%0d] got %b required 1", k, b1);
            end
        end
    endtask

    task automatic test_error;
        logic [63:0] ta [5] = '{64'd0, 64'd5, 64'd9, 64'd0, 64'd7};
        logic [63:0] tn [5] = '{G, 64'd2, 64'd0, 64'd0, 64'd1};
        int cyc;
        bit to, b1;
        for (int k = 0; k < 5; k++) begin
            launch(ta[k], tn[k]);
            collect(20, 1'b0, cyc, to, b1);
            n_chk += 3;
            if (to || cyc != 1) begin
                n_fail++;
                $display("FAIL err_cycle[%0d] got %0d required 1", k, cyc);
            end
            if (inv_out !== 64'd0 || err_out !== 1'b1) begin
                n_fail++;
                $display("FAIL err_res[%0d] got %h/%b required 0/1", k, inv_out, err_out);
            end
            repeat (3) @(negedge clk);
            if (vld_cnt != 0) begin
                n_fail++;
                $display("FAIL err_pulses[%0d] got %0d required 0", k, vld_cnt);
            end
        end
    endtask

    task automatic test_random;
        logic [63:0] primes [9] = '{64'd7, 64'd11, 64'd13, 64'd101, 64'd65537,
                                    64'd2147483647, 64'h1FFFFFFFFFFFFFFF, G,
                                    64'hFFFFFFFFFFFFFFC5};
        logic [63:0] a, n, e;
        int cyc, ec;
        bit to, b1;
        for (int k = 0; k < 20; k++) begin
            n = primes[$urandom_range(0, 8)];
            a = {$urandom, $urandom};
            if (k % 3 == 0) a = a % n;
            if (a == 0) a = 64'd1;
            e = modpow(a, n - 64'd2, n);
            ec = exp_cycle(n);
            launch(a, n);
            collect(ec + 20, 1'b0, cyc, to, b1);
            n_chk += 4;
            if (to || cyc != ec) begin
                n_fail++;
                $display("FAIL rand_cycle[%0d] got %0d required %0d", k, cyc, ec);
            end
            if (inv_out !== e || err_out !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_inv[%0d] a=%h n=%h got %h required %h", k, a, n, inv_out, e);
            end
            if (vld_cnt != 64 + $countones(n - 64'd2)) begin
                n_fail++;
                $display("FAIL rand_pulses[%0d] got %0d required %0d", k, vld_cnt,
                         64 + $countones(n - 64'd2));
            end
            if (consec != 0) begin
                n_fail++;
                $display("FAIL rand_spacing[%0d] back-to-back strobes %0d required 0", k, consec);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] a2;
        int cyc, ec;
        bit to, b1;
        ec = exp_cycle(64'd13);
        launch(64'd5, 64'd13);
        collect(ec + 20, 1'b1, cyc, to, b1);
        n_chk += 2;
        if (to || cyc != ec || inv_out !== 64'd8) begin
            n_fail++;
            $display("FAIL b2b_first got cyc=%0d inv=%h required cyc=%0d inv=8", cyc, inv_out, ec);
        end
        a2 = 64'd3 + 64'($urandom_range(0, 90));
        a_in = a2;
        n_in = 64'd101;
        cur_n = 64'd101;
        @(negedge clk);
        if (busy_out !== 1'b0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL b2b_idle busy=%b dones=%0d required 0 1", busy_out, done_cnt);
        end
        @(posedge clk);
        vld_cnt = 0;
        ec = exp_cycle(64'd101);
        collect(ec + 20, 1'b0, cyc, to, b1);
        n_chk += 2;
        if (b1 !== 1'b1 || to || cyc != ec) begin
            n_fail++;
            $display("FAIL b2b_second busy=%b cyc=%0d required 1 %0d", b1, cyc, ec);
        end
        if (inv_out !== modpow(a2, 64'd99, 64'd101)) begin
            n_fail++;
            $display("FAIL b2b_inv got %h required %h", inv_out, modpow(a2, 64'd99, 64'd101));
        end
    endtask

    task automatic test_reset_abort;
        int cyc;
        bit to, b1;
        launch(64'd2, G);
        @(negedge clk);
        start_in = 1'b0;
        repeat (98) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk += 2;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || mif.mul_vld_out !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ctl busy=%b done=%b vld=%b required 0", busy_out, done_out,
                     mif.mul_vld_out);
        end
        if (inv_out !== 64'd0 || err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_res inv=%h err=%b required 0", inv_out, err_out);
        end
        done_cnt = 0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL abort_done got %0d pulses required 0", done_cnt);
        end
        launch(64'd2, G);
        collect(656, 1'b0, cyc, to, b1);
        n_chk++;
        if (to || cyc != 636 || inv_out !== 64'h7FFFFFFF80000001) begin
            n_fail++;
            $display("FAIL abort_fresh cyc=%0d inv=%h required 636 7fffffff80000001", cyc, inv_out);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset;
        test_known;
        test_error;
        test_random;
        test_back_to_back;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
